morse_char_assembler: RTL
=========================

# morse_char_assembler

Parametrised character assembler that sits between `morse_decoder`, which produces single-cycle dot/dash/letter-gap/word-gap pulses, and `sseg_driver`. It collects dot/dash elements into a symbol register and decodes each completed symbol to a 6-bit character code. Each code is pushed into a DEPTH-slot scrolling display buffer, and word gaps insert a single space. It replaces the fixed 5-bit shift register, the shift counter and the raw-pattern display path with configurable symbol length, buffer depth, error detection and a clear input.

## Interface
- `MAX_SYMBOLS`, default 5: maximum elements per symbol; range 5..8.
- `DEPTH`, default 8: number of display character slots; must be at least 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `dot`  in  1  single-cycle dot element pulse.
- `dash`  in  1  single-cycle dash element pulse.
- `lg`  in  1  single-cycle letter-gap pulse.
- `wg`  in  1  single-cycle word-gap pulse.
- `clear`  in  1  synchronous clear of the symbol register and the buffer.
- `chars`  out  6*DEPTH  display buffer. Slot k is at bits [6k+5:6k]; slot 0 holds the newest character.
- `slot_valid`  out  DEPTH  per-slot occupied flags.
- `char_out`  out  6  most recently emitted code.
- `char_valid`  out  1  one-cycle pulse when `char_out` is updated.
- `sym_pattern`  out  MAX_SYMBOLS  live element pattern.
- `sym_count`  out  $clog2(MAX_SYMBOLS+1)  live element count.
- `sym_err`  out  1  current symbol has overflowed.

## Operation
- Code map:
  - 0–25 = A–Z.
  - 26–35 = digits 0–9.
  - 62 = space.
  - 63 = unknown/error.
- Element capture:
  - An element is accepted when exactly one of `dot` and `dash` is high. Both high at once is ignored, with no state change.
  - On acceptance, `sym_pattern` <= {sym_pattern[MAX_SYMBOLS-2:0], dash}; dash = 1, dot = 0. The first element therefore ends up in the highest occupied bit.
  - `sym_count` increments, saturating at MAX_SYMBOLS.
  - An element accepted while `sym_count` == MAX_SYMBOLS sets `sym_err`. The pattern stops shifting.
- Letter end (`lg`, or `wg`, when `sym_count` > 0):
  - The code is looked up from (`sym_count`, `sym_pattern`). An undefined pattern, or `sym_err` = 1, gives code 63.
  - The code is pushed: slots shift up by one, slot DEPTH-1 is discarded, and the new code enters slot 0 with `slot_valid[0]` set.
  - `char_out` and `char_valid` are updated.
  - `sym_pattern`, `sym_count` and `sym_err` are cleared.
- Letter gap with `sym_count` == 0: no push and no pulse.
- Word gap (`wg`):
  - Performs the letter end first.
  - Then pushes a space (62), unless the newest character, after any letter push, is already a space or the buffer is empty.
  - If the letter and the space both apply, two pushes happen in one cycle. Slot 1 gets the letter, slot 0 gets the space, and `char_out` = 62.
- Element in the same cycle as `lg`/`wg`: the gap closes the old symbol. The new element starts a fresh symbol, with count 1 and the pattern set to that element.
- `clear`:
  - Zeroes all state: pattern, count, error, chars and slot_valid.
  - `char_valid` = 0 that cycle.
  - `clear` has priority over all other inputs in the same cycle.
- Reset values: every output is 0. `chars` is 0 and `slot_valid` is 0; `char_out` = 0 and `char_valid` = 0.

## Timing
- All outputs are registered.
- A gap pulse at edge t produces `char_valid` high for the one cycle after t, with the buffer already updated.
- `sym_pattern`/`sym_count` reflect an element in the cycle after its pulse.
- Back-to-back pulses on consecutive cycles are all honoured; no input is dropped except the simultaneous dot+dash case.
- Deasserting `reset_n` mid-symbol discards the partial symbol. There is no resynchronisation of the inputs inside the block; they come from the clocked decoder.

## Structure
- Shared package `morse_pkg` holds:
  - the code constants `CH_SPACE` = 62 and `CH_ERR` = 63;
  - the 6-bit `char_t` width;
  - the `char_to_sseg` helper used by the display path.
- Sub-module `morse_lut` is purely combinational: (count, pattern) -> code. It covers the 26 letters and 10 digits. Patterns longer than 5 elements return `CH_ERR`.
- The top level holds the symbol register, the gap/push control and the buffer shift logic.

## Test plan
- dot, dash, lg -> `char_valid` pulse with `char_out` = 0 (A), `chars[5:0]` = 0 and `slot_valid` = 8'b00000001.
- dot×3, lg, dash×3, lg, dot×3, wg -> slots 3..0 = 18 (S), 14 (O), 18 (S), 62. A second wg pushes nothing.
- dash×5, lg -> code 26 (digit 0). Then six dots, lg -> `sym_err` = 1 before the lg, and the pushed code is 63.
- Push 10 letters with DEPTH = 8 -> the oldest two are discarded, and `slot_valid` = 8'hFF.
- dot and dash in the same cycle -> `sym_count` unchanged. Then lg with a simultaneous dot -> the old letter is pushed and `sym_count` = 1.
- `clear`, or `reset_n` low, mid-symbol and with the buffer full -> all outputs 0 on the next edge (asynchronously for reset).

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse character definitions: code width, special codes, 7-segment mapping.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package morse_pkg;

  typedef logic [5:0] char_t;
  typedef logic [6:0] sseg_t;

  localparam char_t CH_SPACE = 6'd62;
  localparam char_t CH_ERR   = 6'd63;

  // Active-high segments ordered {g,f,e,d,c,b,a}. Letters use the usual
  // mixed-case approximations; space is blank and error shows a lone dash.
  function automatic sseg_t char_to_sseg(input char_t c);
    sseg_t s;
    case (c)
      6'd0:  s = 7'h77;  6'd1:  s = 7'h7C;  6'd2:  s = 7'h39;  6'd3:  s = 7'h5E;
      6'd4:  s = 7'h79;  6'd5:  s = 7'h71;  6'd6:  s = 7'h3D;  6'd7:  s = 7'h76;
      6'd8:  s = 7'h30;  6'd9:  s = 7'h1E;  6'd10: s = 7'h75;  6'd11: s = 7'h38;
      6'd12: s = 7'h37;  6'd13: s = 7'h54;  6'd14: s = 7'h5C;  6'd15: s = 7'h73;
      6'd16: s = 7'h67;  6'd17: s = 7'h50;  6'd18: s = 7'h6D;  6'd19: s = 7'h78;
      6'd20: s = 7'h3E;  6'd21: s = 7'h1C;  6'd22: s = 7'h2A;  6'd23: s = 7'h64;
      6'd24: s = 7'h6E;  6'd25: s = 7'h5B;
      6'd26: s = 7'h3F;  6'd27: s = 7'h06;  6'd28: s = 7'h5B;  6'd29: s = 7'h4F;
      6'd30: s = 7'h66;  6'd31: s = 7'h6D;  6'd32: s = 7'h7D;  6'd33: s = 7'h07;
      6'd34: s = 7'h7F;  6'd35: s = 7'h6F;
      CH_SPACE: s = 7'h00;
      default:  s = 7'h40;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Symbol decoder: (element count, dash pattern) -> 6-bit character code.
// Latency: purely combinational.
// Backpressure: none; evaluated continuously on the live symbol register.
module morse_lut
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 5,
  parameter int CW          = 3
) (
  input  logic [CW-1:0]          count_i,
  input  logic [MAX_SYMBOLS-1:0] pattern_i,
  output char_t                  code_o
);

  // Zero-extended pattern; bits above the element count must be zero for a
  // match, so longer-than-supported symbols naturally fall to CH_ERR.
  logic [7:0] p8;
  assign p8 = 8'(pattern_i);

  // Table lookup keyed on length first; first element sits in the top occupied bit.
  always_comb begin
    code_o = CH_ERR;
    case (int'(count_i))
      1: case (p8)
           8'b0: code_o = 6'd4;   // E
           8'b1: code_o = 6'd19;  // T
           default: ;
         endcase
      2: case (p8)
           8'b00: code_o = 6'd8;   // I
           8'b01: code_o = 6'd0;   // A
           8'b10: code_o = 6'd13;  // N
           8'b11: code_o = 6'd12;  // M
           default: ;
         endcase
      3: case (p8)
           8'b000: code_o = 6'd18;  // S
           8'b001: code_o = 6'd20;  // U
           8'b010: code_o = 6'd17;  // R
           8'b011: code_o = 6'd22;  // W
           8'b100: code_o = 6'd3;   // D
           8'b101: code_o = 6'd10;  // K
           8'b110: code_o = 6'd6;   // G
           8'b111: code_o = 6'd14;  // O
           default: ;
         endcase
      4: case (p8)
           8'b0000: code_o = 6'd7;   // H
           8'b0001: code_o = 6'd21;  // V
           8'b0010: code_o = 6'd5;   // F
           8'b0100: code_o = 6'd11;  // L
           8'b0110: code_o = 6'd15;  // P
           8'b0111: code_o = 6'd9;   // J
           8'b1000: code_o = 6'd1;   // B
           8'b1001: code_o = 6'd23;  // X
           8'b1010: code_o = 6'd2;   // C
           8'b1011: code_o = 6'd24;  // Y
           8'b1100: code_o = 6'd25;  // Z
           8'b1101: code_o = 6'd16;  // Q
           default: ;
         endcase
      5: case (p8)
           8'b11111: code_o = 6'd26;  // 0
           8'b01111: code_o = 6'd27;  // 1
           8'b00111: code_o = 6'd28;  // 2
           8'b00011: code_o = 6'd29;  // 3
           8'b00001: code_o = 6'd30;  // 4
           8'b00000: code_o = 6'd31;  // 5
           8'b10000: code_o = 6'd32;  // 6
           8'b11000: code_o = 6'd33;  // 7
           8'b11100: code_o = 6'd34;  // 8
           8'b11110: code_o = 6'd35;  // 9
           default: ;
         endcase
      default: ;
    endcase
  end

endmodule

// File: rtl/morse_char_assembler.sv
// Collects dot/dash pulses into symbols, decodes them and scrolls codes into a DEPTH-slot buffer.
// Latency: one cycle from gap/element pulse to registered outputs.
// Backpressure: none; every pulse is consumed in its cycle (simultaneous dot+dash is dropped).
module morse_char_assembler
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 5,
  parameter int DEPTH       = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               dot,
  input  logic                               dash,
  input  logic                               lg,
  input  logic                               wg,
  input  logic                               clear,
  output logic [6*DEPTH-1:0]                 chars,
  output logic [DEPTH-1:0]                   slot_valid,
  output logic [5:0]                         char_out,
  output logic                               char_valid,
  output logic [MAX_SYMBOLS-1:0]             sym_pattern,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0]   sym_count,
  output logic                               sym_err
);

  localparam int CW = $clog2(MAX_SYMBOLS+1);

  logic [MAX_SYMBOLS-1:0] pat_q, pat_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [6*DEPTH-1:0]     chars_q, chars_d, chars_l;
  logic [DEPTH-1:0]       vld_q, vld_d, vld_l;
  char_t                  out_q, out_d;
  logic                   cv_q, cv_d;

  char_t lut_code, letter_code;
  logic  elem, gap, close_sym, sp_push;

  morse_lut #(
    .MAX_SYMBOLS (MAX_SYMBOLS),
    .CW          (CW)
  ) u_lut (
    .count_i   (cnt_q),
    .pattern_i (pat_q),
    .code_o    (lut_code)
  );

  assign elem        = dot ^ dash;
  assign gap         = lg | wg;
  assign close_sym   = gap && (cnt_q != '0);
  assign letter_code = err_q ? CH_ERR : lut_code;

  // Symbol register: a gap empties it first, so an element in the same cycle starts a fresh symbol.
  always_comb begin
    pat_d = pat_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (gap) begin
      pat_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end
    if (elem) begin
      if (cnt_d == CW'(MAX_SYMBOLS)) begin
        err_d = 1'b1;
      end else begin
        pat_d = {pat_d[MAX_SYMBOLS-2:0], dash};
        cnt_d = cnt_d + CW'(1);
      end
    end
    if (clear) begin
      pat_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end
  end

  // Buffer: letter push, then an optional space push judged on the post-letter newest slot.
  always_comb begin
    chars_l = chars_q;
    vld_l   = vld_q;
    if (close_sym) begin
      chars_l = {chars_q[6*DEPTH-7:0], letter_code};
      vld_l   = {vld_q[DEPTH-2:0], 1'b1};
    end
    sp_push = wg && vld_l[0] && (chars_l[5:0] != CH_SPACE);
    chars_d = chars_l;
    vld_d   = vld_l;
    if (sp_push) begin
      chars_d = {chars_l[6*DEPTH-7:0], CH_SPACE};
      vld_d   = {vld_l[DEPTH-2:0], 1'b1};
    end
    out_d = out_q;
    cv_d  = 1'b0;
    if (close_sym) begin
      out_d = letter_code;
      cv_d  = 1'b1;
    end
    if (sp_push) begin
      out_d = CH_SPACE;
      cv_d  = 1'b1;
    end
    if (clear) begin
      chars_d = '0;
      vld_d   = '0;
      out_d   = '0;
      cv_d    = 1'b0;
    end
  end

  // State registers; reset discards any partial symbol and the whole buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      chars_q <= '0;
      vld_q   <= '0;
      out_q   <= '0;
      cv_q    <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      chars_q <= chars_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
      cv_q    <= cv_d;
    end
  end

  assign chars       = chars_q;
  assign slot_valid  = vld_q;
  assign char_out    = out_q;
  assign char_valid  = cv_q;
  assign sym_pattern = pat_q;
  assign sym_count   = cnt_q;
  assign sym_err     = err_q;

endmodule
